// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port memory between the cpu (priority) and a DMA master; MEM_ARB_ROM_PROTECT_EN blocks DMA writes at or above ROM_BASE.
// Latency: address/data/we mux is combinational; cpu_rdata and dma_rdata/dma_rvalid appear one cycle after their slot.
// Backpressure: cpu_rdy drops while the DMA owns the bus; a pending DMA request waits at most CPU_BURST cycles for dma_gnt.
module mem_arbiter #(
   parameter int unsigned CPU_BURST = 4,
   parameter int unsigned DMA_BURST = 2,
   parameter logic [15:0] ROM_BASE  = 16'hE000
) (
   input  logic        CLK,
   input  logic        R,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_we,
   output logic        cpu_rdy,
   output logic [7:0]  cpu_rdata,
   input  logic        dma_req,
   input  logic [15:0] dma_addr,
   input  logic [7:0]  dma_wdata,
   input  logic        dma_we,
   output logic        dma_gnt,
   output logic        dma_rvalid,
   output logic [7:0]  dma_rdata,
   output logic        dma_err,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_we,
   input  logic [7:0]  mem_rdata
);

   typedef enum logic {
      S_CPU = 1'b0,
      S_DMA = 1'b1
   } owner_t;

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  dat;
      logic        we;
   } mem_req_t;

   localparam logic [2:0] CPU_LAST = 3'(CPU_BURST - 1);
   localparam logic [2:0] DMA_LAST = 3'(DMA_BURST - 1);

   owner_t     owner_q, owner_d;
   logic [2:0] cpu_run_q, cpu_run_d;
   logic [2:0] dma_run_q, dma_run_d;
   logic       last_cpu_rd_q;
   logic [7:0] rd_hold_q;
   logic       dma_rvalid_q;
   logic       dma_acc;
   logic       rom_hit;
   mem_req_t   cpu_bus, dma_bus, mem_bus;

   assign cpu_bus = {cpu_addr, cpu_wdata, cpu_we};
   assign dma_bus = {dma_addr, dma_wdata, dma_we};

`ifdef MEM_ARB_ROM_PROTECT_EN
   assign rom_hit = (dma_addr >= ROM_BASE);
`else
   assign rom_hit = 1'b0;
   logic unused_rom_base;
   assign unused_rom_base = ^ROM_BASE;
`endif

   // Next owner, run counters and the bus mux, all from the registered owner.
   always_comb begin
      owner_d   = owner_q;
      cpu_run_d = cpu_run_q;
      dma_run_d = dma_run_q;
      mem_bus   = cpu_bus;
      cpu_rdy   = 1'b1;
      dma_gnt   = 1'b0;

      case (owner_q)
         S_CPU: begin
            if (!dma_req) begin
               cpu_run_d = 3'd0;
            end else if (cpu_run_q == CPU_LAST) begin
               owner_d   = S_DMA;
               dma_run_d = 3'd0;
            end else if (cpu_run_q != 3'd7) begin
               cpu_run_d = cpu_run_q + 3'd1;
            end
         end
         S_DMA: begin
            cpu_rdy = 1'b0;
            if (dma_req) begin
               mem_bus = dma_bus;
               dma_gnt = 1'b1;
               if (rom_hit) begin
                  mem_bus.we = 1'b0;
               end
            end else begin
               mem_bus.we = 1'b0;
            end
            if (dma_req && (dma_run_q < DMA_LAST)) begin
               dma_run_d = dma_run_q + 3'd1;
            end else begin
               owner_d   = S_CPU;
               cpu_run_d = 3'd0;
            end
         end
      endcase

      if (R) begin
         mem_bus.we = 1'b0;
         dma_gnt    = 1'b0;
         cpu_rdy    = 1'b0;
      end
   end

   assign dma_acc = dma_req && dma_gnt;

   always_ff @(posedge CLK) begin
      if (R) begin
         owner_q       <= S_CPU;
         cpu_run_q     <= 3'd0;
         dma_run_q     <= 3'd0;
         last_cpu_rd_q <= 1'b0;
         rd_hold_q     <= 8'd0;
         dma_rvalid_q  <= 1'b0;
      end else begin
         owner_q       <= owner_d;
         cpu_run_q     <= cpu_run_d;
         dma_run_q     <= dma_run_d;
         last_cpu_rd_q <= (owner_q == S_CPU) && !mem_bus.we;
         if (last_cpu_rd_q) begin
            rd_hold_q <= mem_rdata;
         end
         dma_rvalid_q  <= dma_acc && !dma_we;
      end
   end

`ifdef MEM_ARB_ROM_PROTECT_EN
   logic dma_err_q;

   always_ff @(posedge CLK) begin
      if (R) begin
         dma_err_q <= 1'b0;
      end else begin
         dma_err_q <= dma_acc && dma_we && rom_hit;
      end
   end

   assign dma_err = dma_err_q && !R;
`else
   assign dma_err = 1'b0;
`endif

   // A DMA slot never disturbs what the cpu last read.
   assign cpu_rdata  = last_cpu_rd_q ? mem_rdata : rd_hold_q;
   assign dma_rvalid = dma_rvalid_q;
   assign dma_rdata  = mem_rdata;
   assign mem_addr   = mem_bus.addr;
   assign mem_wdata  = mem_bus.dat;
   assign mem_we     = mem_bus.we;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a slot-level model with its own copy of memory.
module tb_mem_arbiter;

   localparam int          CPU_BURST = 4;
   localparam int          DMA_BURST = 2;
   localparam logic [15:0] ROM_BASE  = 16'hE000;
`ifdef MEM_ARB_ROM_PROTECT_EN
   localparam bit PROT = 1'b1;
`else
   localparam bit PROT = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        R;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_we;
   logic        cpu_rdy;
   logic [7:0]  cpu_rdata;
   logic        dma_req;
   logic [15:0] dma_addr;
   logic [7:0]  dma_wdata;
   logic        dma_we;
   logic        dma_gnt;
   logic        dma_rvalid;
   logic [7:0]  dma_rdata;
   logic        dma_err;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic [7:0]  mem_rdata;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] mem_array [0:65535];
   logic [7:0] ref_mem   [0:65535];

   mem_arbiter #(
      .CPU_BURST(CPU_BURST),
      .DMA_BURST(DMA_BURST),
      .ROM_BASE (ROM_BASE)
   ) dut (
      .CLK       (CLK),
      .R         (R),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_we    (cpu_we),
      .cpu_rdy   (cpu_rdy),
      .cpu_rdata (cpu_rdata),
      .dma_req   (dma_req),
      .dma_addr  (dma_addr),
      .dma_wdata (dma_wdata),
      .dma_we    (dma_we),
      .dma_gnt   (dma_gnt),
      .dma_rvalid(dma_rvalid),
      .dma_rdata (dma_rdata),
      .dma_err   (dma_err),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata)
   );

   always #5 CLK = ~CLK;

   // Single-port memory, one-cycle read latency.
   always @(posedge CLK) begin
      mem_rdata <= mem_array[mem_addr];
      if (mem_we) mem_array[mem_addr] = mem_wdata;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [15:0] pick_addr();
      logic [15:0] a;
      case ($urandom_range(0, 2))
         0:       a = 16'h0200 + 16'($urandom_range(0, 7));
         1:       a = 16'h0010 + 16'($urandom_range(0, 7));
         default: a = ROM_BASE + 16'($urandom_range(0, 3));
      endcase
      return a;
   endfunction

   // Slot-level model: who owns each cycle, what memory holds, what each master must see.
   bit         m_dma;
   int         m_cpu_wait;
   int         m_dma_left;
   logic [7:0] m_cpu_data;
   logic [7:0] m_dma_data;
   bit         m_rvalid;
   bit         m_err;

   always @(negedge CLK) begin
      logic [15:0] e_addr;
      logic [7:0]  e_wd;
      bit          e_we, acc, prot_hit;
      if (R) begin
         chk("rst_cpu_rdy", cpu_rdy, 0);
         chk("rst_dma_gnt", dma_gnt, 0);
         chk("rst_mem_we",  mem_we,  0);
         chk("rst_dma_err", dma_err, 0);
         m_dma = 0; m_cpu_wait = 0; m_dma_left = 0;
         m_cpu_data = 8'h00; m_rvalid = 0; m_err = 0;
      end else begin
         acc      = m_dma && dma_req;
         prot_hit = PROT && (dma_addr >= ROM_BASE);
         if (!m_dma) begin
            e_addr = cpu_addr; e_wd = cpu_wdata; e_we = cpu_we;
         end else if (dma_req) begin
            e_addr = dma_addr; e_wd = dma_wdata; e_we = dma_we && !prot_hit;
         end else begin
            e_addr = cpu_addr; e_wd = cpu_wdata; e_we = 0;
         end
         chk("cpu_rdy",    cpu_rdy,    !m_dma);
         chk("dma_gnt",    dma_gnt,    acc);
         chk("mem_addr",   mem_addr,   e_addr);
         chk("mem_we",     mem_we,     e_we);
         if (e_we) chk("mem_wdata", mem_wdata, e_wd);
         chk("cpu_rdata",  cpu_rdata,  m_cpu_data);
         chk("dma_rvalid", dma_rvalid, m_rvalid);
         if (m_rvalid) chk("dma_rdata", dma_rdata, m_dma_data);
         chk("dma_err",    dma_err,    m_err);

         if (e_we) ref_mem[e_addr] = e_wd;
         if (!m_dma && !cpu_we) m_cpu_data = ref_mem[cpu_addr];
         m_rvalid = acc && !dma_we;
         if (m_rvalid) m_dma_data = ref_mem[dma_addr];
         m_err = acc && dma_we && prot_hit;

         if (!m_dma) begin
            if (!dma_req) m_cpu_wait = 0;
            else begin
               m_cpu_wait++;
               if (m_cpu_wait >= CPU_BURST) begin
                  m_dma = 1; m_dma_left = DMA_BURST;
               end
            end
         end else begin
            m_dma_left--;
            if (!dma_req || m_dma_left == 0) begin
               m_dma = 0; m_cpu_wait = 0;
            end
         end
      end
   end

   initial begin
      for (int a = 0; a < 65536; a++) begin
         mem_array[a] = 8'(a) ^ 8'(a >> 8);
         ref_mem[a]   = 8'(a) ^ 8'(a >> 8);
      end
      mem_array[16'h0200] = 8'h5A; ref_mem[16'h0200] = 8'h5A;
      mem_array[16'h0300] = 8'hC3; ref_mem[16'h0300] = 8'hC3;
      mem_array[16'hE000] = 8'hA5; ref_mem[16'hE000] = 8'hA5;
   end

   initial begin
      bit adv, acc;
      int pct;
      R = 1; cpu_addr = 16'h0200; cpu_wdata = 0; cpu_we = 0;
      dma_req = 0; dma_addr = 0; dma_wdata = 0; dma_we = 0;
      repeat (3) tick();
      #3;
      chk("lit_rst_rdy", cpu_rdy, 0);
      chk("lit_rst_we",  mem_we,  0);

      // cycles 0..9: cpu read stream, no DMA
      tick(); R = 0;
      for (int c = 0; c < 10; c++) begin
         if (c > 0) tick();
         #3;
         chk("lit_stream_rdy",  cpu_rdy,  1);
         chk("lit_stream_gnt",  dma_gnt,  0);
         chk("lit_stream_addr", mem_addr, 16'h0200);
         if (c == 0) chk("lit_rdata_after_rst", cpu_rdata, 8'h00);
         if (c == 1) chk("lit_rdata_5a",        cpu_rdata, 8'h5A);
      end

      // cycle 10: DMA read 0x0300 requested; grant expected at cycle 14
      tick(); dma_req = 1; dma_addr = 16'h0300; dma_we = 0;
      for (int c = 10; c < 14; c++) begin
         if (c > 10) tick();
         #3;
         chk("lit_wait_gnt", dma_gnt, 0);
         chk("lit_wait_rdy", cpu_rdy, 1);
      end
      tick(); cpu_addr = 16'h0010;                         // cycle 14
      #3; chk("lit_c14_gnt", dma_gnt, 1); chk("lit_c14_rdy", cpu_rdy, 0);
      tick(); dma_addr = 16'h0010; dma_we = 1; dma_wdata = 8'h77;  // cycle 15
      #3;
      chk("lit_c15_gnt",    dma_gnt,    1);
      chk("lit_c15_rvalid", dma_rvalid, 1);
      chk("lit_c15_drdata", dma_rdata,  8'hC3);
      chk("lit_c15_crdata", cpu_rdata,  8'h5A);
      tick(); dma_req = 0;                                  // cycle 16
      #3; chk("lit_c16_rdy", cpu_rdy, 1); chk("lit_c16_crdata", cpu_rdata, 8'h5A);
      tick();                                               // cycle 17
      #3; chk("lit_dma_wr_seen", cpu_rdata, 8'h77);

      // cycle 18: DMA read, dropped after first slot -> idle slot at 23
      tick(); dma_req = 1; dma_addr = 16'h0300; dma_we = 0;
      repeat (3) tick();
      tick(); cpu_addr = 16'h0020; cpu_we = 1; cpu_wdata = 8'h99;  // cycle 22
      #3; chk("lit_c22_gnt", dma_gnt, 1);
      tick(); dma_req = 0;                                  // cycle 23
      #3;
      chk("lit_idle_rdy",    cpu_rdy,    0);
      chk("lit_idle_gnt",    dma_gnt,    0);
      chk("lit_idle_we",     mem_we,     0);
      chk("lit_idle_rvalid", dma_rvalid, 1);
      tick();                                               // cycle 24
      #3; chk("lit_c24_rdy", cpu_rdy, 1); chk("lit_c24_we", mem_we, 1);
      tick(); cpu_we = 0;                                   // cycle 25
      tick(); cpu_addr = 16'h0200;                          // cycle 26
      dma_req = 1; dma_addr = 16'h0300; dma_we = 0;
      #3; chk("lit_cpu_wr_seen", cpu_rdata, 8'h99);

      // reset during the 2nd DMA slot (cycle 31)
      repeat (3) tick();
      tick();                                               // cycle 30
      #3; chk("lit_c30_gnt", dma_gnt, 1);
      tick(); R = 1; dma_addr = 16'h0040; dma_we = 1; dma_wdata = 8'hEE;  // cycle 31
      #3;
      chk("lit_midrst_we",  mem_we,  0);
      chk("lit_midrst_rdy", cpu_rdy, 0);
      chk("lit_midrst_gnt", dma_gnt, 0);
      tick(); R = 0; dma_addr = ROM_BASE; dma_we = 1; dma_wdata = 8'h11;  // cycle 32
      #3;
      chk("lit_postrst_rdy",    cpu_rdy,    1);
      chk("lit_postrst_rvalid", dma_rvalid, 0);
      chk("lit_postrst_crdata", cpu_rdata,  8'h00);

      // protected write at cycle 36, readback at 37
      repeat (3) tick();
      tick();                                               // cycle 36
      #3; chk("lit_rom_gnt", dma_gnt, 1); chk("lit_rom_we", mem_we, PROT ? 0 : 1);
      tick(); dma_we = 0;                                   // cycle 37
      #3; chk("lit_rom_err", dma_err, PROT);
      tick(); dma_req = 0;                                  // cycle 38
      #3;
      chk("lit_rom_rvalid", dma_rvalid, 1);
      chk("lit_rom_rdata",  dma_rdata,  PROT ? 8'hA5 : 8'h11);
      chk("lit_rom_err_end", dma_err,   0);

      // randomized traffic with varying DMA pressure and occasional reset
      for (int i = 0; i < 4000; i++) begin
         adv = cpu_rdy;
         acc = dma_req && dma_gnt;
         pct = 25 * (1 + (i / 500) % 4);
         tick();
         R = ($urandom_range(0, 249) == 0);
         if (adv) begin
            cpu_addr  = pick_addr();
            cpu_we    = ($urandom_range(0, 3) == 0);
            cpu_wdata = 8'($urandom);
         end
         if (acc || !dma_req) begin
            dma_req   = ($urandom_range(0, 99) < pct);
            dma_addr  = pick_addr();
            dma_we    = 1'($urandom_range(0, 1));
            dma_wdata = 8'($urandom);
         end
         #3;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port MEMORY between the cpu core and a secondary bus master (DMA / program loader).
- The cpu has priority. A DMA requester is guaranteed a slot after at most CPU_BURST cpu cycles; the cpu is stalled through cpu_rdy while the DMA owns the bus.
- Buffers cpu read data across stall slots so the cpu never sees DMA read data.
- Sits between cpu address/data outputs and MEMORY Address/DataIn/DataOut/WE.

Parameters:
- CPU_BURST, 4, max consecutive cpu cycles while dma_req is pending (must be >= 1)
- DMA_BURST, 2, max consecutive DMA-owned cycles per grant window (must be >= 1)
- ROM_BASE, 16'hE000, lowest protected address (used only with the optional feature)

Ports:
- CLK  in  1  clock, all state on rising edge
- R  in  1  reset, synchronous, active-high
- cpu_addr  in  16  cpu address
- cpu_wdata  in  8  cpu write data
- cpu_we  in  1  cpu write enable
- cpu_rdy  out  1  cpu may advance this cycle; cpu holds addr/wdata/we while low
- cpu_rdata  out  8  cpu read data, valid the cycle after a cpu read slot and held afterwards
- dma_req  in  1  DMA request, held with addr/wdata/we until accepted
- dma_addr  in  16  DMA address
- dma_wdata  in  8  DMA write data
- dma_we  in  1  DMA write enable
- dma_gnt  out  1  DMA owns the current cycle; access accepted when dma_req && dma_gnt
- dma_rvalid  out  1  pulses 1 cycle after an accepted DMA read
- dma_rdata  out  8  read data, valid when dma_rvalid
- dma_err  out  1  protected-write pulse (optional feature); tied 0 otherwise
- mem_addr  out  16  to MEMORY Address
- mem_wdata  out  8  to MEMORY DataIn
- mem_we  out  1  to MEMORY WE
- mem_rdata  in  8  from MEMORY DataOut; one-cycle read latency

Behaviour:
- State register owner: S_CPU (0) or S_DMA (1). Counters cpu_run and dma_run, each 3 bits, saturating.
- Mux, combinational from the registered state:
  - S_CPU: mem_* = cpu_*; cpu_rdy=1; dma_gnt=0.
  - S_DMA: cpu_rdy=0. With dma_req=1: mem_* = dma_*, dma_gnt=1. With dma_req=0: idle slot, mem_addr=cpu_addr, mem_we=0, dma_gnt=0.
- S_CPU transitions:
  - dma_req=0: cpu_run<=0, stay.
  - dma_req=1 and cpu_run==CPU_BURST-1: go to S_DMA, dma_run<=0.
  - otherwise: cpu_run++.
- S_DMA transitions:
  - dma_req=1 and dma_run<DMA_BURST-1: stay, dma_run++.
  - otherwise: go to S_CPU, cpu_run<=0.
- Worst-case DMA wait: CPU_BURST cycles from dma_req rise to dma_gnt. With CPU_BURST=1 the slots alternate cpu/DMA.
- last_cpu_rd register: set when the previous cycle was a cpu slot with mem_we=0.
  - cpu_rdata = last_cpu_rd ? mem_rdata : rd_hold.
  - rd_hold <= mem_rdata whenever last_cpu_rd=1.
  - cpu_rdata therefore stays stable through any number of DMA slots.
- dma_rvalid <= accepted DMA access with dma_we=0. dma_rdata = mem_rdata, meaningful only while dma_rvalid=1.
- Write in a slot takes effect at the slot's rising edge; a read of the same address in the next slot returns the new value.
- Reset (R=1 at edge):
  - owner=S_CPU, cpu_run=0, dma_run=0, rd_hold=0, last_cpu_rd=0, dma_rvalid=0.
  - While R=1, outputs forced combinationally: mem_we=0, dma_gnt=0, cpu_rdy=0, dma_err=0.
  - Reset mid DMA burst drops the burst; no rvalid for an access in the reset cycle.
  - First cycle after reset is a cpu slot.

Optional Feature:
- Macro: MEM_ARB_ROM_PROTECT_EN.
- Defined: an accepted DMA write with dma_addr >= ROM_BASE is suppressed (mem_we=0) and consumes its slot. dma_err is registered and pulses high for 1 cycle after that slot. cpu writes are never suppressed.
- Undefined: no address compare, dma_err constant 0, all accepted DMA writes reach memory.

Test Plan:
- Reset then cpu read stream, dma_req=0 -> cpu_rdy=1 every cycle, mem_addr tracks cpu_addr, dma_gnt=0, cpu_rdata = memory contents 1 cycle later.
- CPU_BURST=4: dma_req rises at cycle 10 and held -> dma_gnt first high at cycle 14, cpu_rdy=0 at cycles 14-15 (DMA_BURST=2), cpu_rdy=1 at cycle 16.
- cpu reads 0x0200 (=0x5A) in the slot before a DMA read of 0x0300 (=0xC3) -> cpu_rdata=0x5A for the whole stall; dma_rvalid=1 with dma_rdata=0xC3.
- DMA writes 0x77 to 0x0010, then the cpu reads 0x0010 -> cpu_rdata=0x77; dma_req dropped inside S_DMA -> one idle slot with mem_we=0, then S_CPU.
- R asserted during the 2nd DMA slot -> next cycle owner=S_CPU, dma_rvalid=0, rd_hold=0; during R: mem_we=0, cpu_rdy=0.
- MEM_ARB_ROM_PROTECT_EN: DMA writes 0x11 to 0xE000 -> mem_we=0, dma_err pulses 1 cycle, a read of 0xE000 returns the old value; without the macro the write lands and dma_err stays 0.
